piso_serializer: RTL and testbench

//   Parallel-in/serial-out transmitter: the sending end of the team's serial-load flop

---
 rtl/piso_serializer.sv | 146 ++++++++++++++
 tb/tb_piso_serializer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word load, MSB-first shift with frame strobe and done pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the LSB of each frame.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  output logic             sout,
  output logic             sframe,
  output logic             sdone
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(NBITS);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ready_q, ready_d;
  logic             sout_q, sout_d;
  logic             sframe_q, sframe_d;
  logic             sdone_q, sdone_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cyc_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      ready_q  <= 1'b0;
      sout_q   <= 1'b0;
      sframe_q <= 1'b0;
      sdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      ready_q  <= ready_d;
      sout_q   <= sout_d;
      sframe_q <= sframe_d;
      sdone_q  <= sdone_d;
    end
  end

  // The bit currently on sout is always shift_q[NBITS-1]; advancing exposes shift_q[NBITS-2].
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    ready_d  = 1'b0;
    sout_d   = sout_q;
    sframe_d = sframe_q;
    sdone_d  = 1'b0;

    case (state_q)
      IDLE: begin
        ready_d  = 1'b1;
        sout_d   = 1'b0;
        sframe_d = 1'b0;
        if (d_valid && ready_q) begin
          state_d  = SHIFT;
`ifdef PISO_PARITY_EN
          shift_d  = {d, ^d};
`else
          shift_d  = d;
`endif
          sout_d   = d[WIDTH-1];
          sframe_d = 1'b1;
          cyc_d    = '0;
          bit_d    = '0;
          ready_d  = 1'b0;
        end
      end

      SHIFT: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d  = GAP;
            gap_d    = '0;
            sout_d   = 1'b0;
            sframe_d = 1'b0;
            sdone_d  = 1'b1;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q << 1;
            sout_d  = shift_q[NBITS-2];
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      GAP: begin
        sout_d   = 1'b0;
        sframe_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        sout_d   = 1'b0;
        sframe_d = 1'b0;
      end
    endcase
  end

  assign d_ready = ready_q;
  assign sout    = sout_q;
  assign sframe  = sframe_q;
  assign sdone   = sdone_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one default instance and one with BIT_CYCLES=3, GAP_CYCLES=2,
// each checked cycle by cycle against a frame model built from the word's bit list.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] d_a, d_b;
  logic       dv_a, dv_b;
  logic       rdy_a, rdy_b;
  logic       sout_a, sout_b;
  logic       sframe_a, sframe_b;
  logic       sdone_a, sdone_b;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(4), .BIT_CYCLES(1), .GAP_CYCLES(1)) u_dut_a (
    .clk(clk), .reset(reset), .d(d_a), .d_valid(dv_a),
    .d_ready(rdy_a), .sout(sout_a), .sframe(sframe_a), .sdone(sdone_a)
  );

  piso_serializer #(.WIDTH(4), .BIT_CYCLES(3), .GAP_CYCLES(2)) u_dut_b (
    .clk(clk), .reset(reset), .d(d_b), .d_valid(dv_b),
    .d_ready(rdy_b), .sout(sout_b), .sframe(sframe_b), .sdone(sdone_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Sends one word through the chosen instance and compares every clock of the frame and gap
  // against a model: bit list = word MSB first (plus even parity), each held bc clocks,
  // sdone on the clock after the frame, d_ready back after gp clocks of gap.
  task automatic run_frame(input int which, input logic [3:0] word, input bit hold_valid,
                           input bit scramble_d);
    int   bc, gp, nb, frame, n;
    logic exp_bits [0:4];
    logic e_sout, e_fr, e_done, e_rdy;
    logic o_sout, o_fr, o_done, o_rdy;
    bc    = (which == 0) ? 1 : 3;
    gp    = (which == 0) ? 1 : 2;
    nb    = 4 + PAR;
    frame = nb * bc;
    for (int i = 0; i < 4; i++) exp_bits[i] = word[3-i];
    exp_bits[4] = ^word;

    n = 0;
    while (((which == 0) ? rdy_a : rdy_b) !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("[TB] FAIL ready_wait dut%0d: d_ready=%b after %0d clocks, required 1", which,
               (which == 0) ? rdy_a : rdy_b, n);
    end

    if (which == 0) begin d_a = word; dv_a = 1'b1; end
    else            begin d_b = word; dv_b = 1'b1; end
    @(posedge clk); #1;

    for (int t = 0; t <= frame + gp; t++) begin
      e_sout = (t < frame) ? exp_bits[t / bc] : 1'b0;
      e_fr   = (t < frame);
      e_done = (t == frame);
      e_rdy  = (t == frame + gp);
      o_sout = (which == 0) ? sout_a   : sout_b;
      o_fr   = (which == 0) ? sframe_a : sframe_b;
      o_done = (which == 0) ? sdone_a  : sdone_b;
      o_rdy  = (which == 0) ? rdy_a    : rdy_b;
      checks += 4;
      if (o_sout !== e_sout) begin
        errors++;
        $display("[TB] FAIL sout dut%0d word=%h t=%0d: got %b, required %b", which, word, t, o_sout, e_sout);
      end
      if (o_fr !== e_fr) begin
        errors++;
        $display("[TB] FAIL sframe dut%0d word=%h t=%0d: got %b, required %b", which, word, t, o_fr, e_fr);
      end
      if (o_done !== e_done) begin
        errors++;
        $display("[TB] FAIL sdone dut%0d word=%h t=%0d: got %b, required %b", which, word, t, o_done, e_done);
      end
      if (o_rdy !== e_rdy) begin
        errors++;
        $display("[TB] FAIL d_ready dut%0d word=%h t=%0d: got %b, required %b", which, word, t, o_rdy, e_rdy);
      end
      if (!hold_valid) begin
        if (which == 0) dv_a = 1'b0; else dv_b = 1'b0;
      end
      if (scramble_d) begin
        if (which == 0) d_a = 4'($urandom); else d_b = 4'($urandom);
      end
      if (t < frame + gp) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checks += 2;
    if ({rdy_a, sout_a, sframe_a, sdone_a} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_vals_a: rdy/sout/sframe/sdone=%b, required 0000",
               {rdy_a, sout_a, sframe_a, sdone_a});
    end
    if ({rdy_b, sout_b, sframe_b, sdone_b} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_vals_b: rdy/sout/sframe/sdone=%b, required 0000",
               {rdy_b, sout_b, sframe_b, sdone_b});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks += 2;
    if ({rdy_a, sout_a, sframe_a, sdone_a} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL post_reset_a: rdy/sout/sframe/sdone=%b, required 1000",
               {rdy_a, sout_a, sframe_a, sdone_a});
    end
    if ({rdy_b, sout_b, sframe_b, sdone_b} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL post_reset_b: rdy/sout/sframe/sdone=%b, required 1000",
               {rdy_b, sout_b, sframe_b, sdone_b});
    end
  endtask

  task automatic test_single_frame();
    run_frame(0, 4'b1011, 1'b0, 1'b0);
  endtask

  task automatic test_bit_cycles();
    run_frame(1, 4'b1000, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(0, 4'hA, 1'b1, 1'b1);
    run_frame(0, 4'h5, 1'b0, 1'b1);
  endtask

  task automatic test_reset_abort();
    d_a  = 4'b1111;
    dv_a = 1'b1;
    @(posedge clk); #1;
    dv_a = 1'b0;
    checks++;
    if ({sout_a, sframe_a} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL abort_first_bit: sout/sframe=%b, required 11", {sout_a, sframe_a});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({rdy_a, sout_a, sframe_a, sdone_a} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL abort_reset_vals: rdy/sout/sframe/sdone=%b, required 0000",
               {rdy_a, sout_a, sframe_a, sdone_a});
    end
    @(posedge clk); #1;
    checks++;
    if (rdy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_ready: d_ready=%b, required 1", rdy_a);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({sdone_a, sframe_a} !== 2'b00) begin
        errors++;
        $display("[TB] FAIL abort_no_sdone k=%0d: sdone/sframe=%b, required 00", k, {sdone_a, sframe_a});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [3:0] w;
    bit         hold;
    int         idle;
    for (int which = 0; which < 2; which++) begin
      for (int i = 0; i < 5; i++) begin
        w    = 4'($urandom);
        hold = (i < 4) ? bit'($urandom_range(0, 1)) : 1'b0;
        run_frame(which, w, hold, 1'b1);
        if (!hold) begin
          idle = $urandom_range(0, 2);
          for (int k = 0; k < idle; k++) begin
            @(posedge clk); #1;
            checks++;
            if (((which == 0) ? {rdy_a, sframe_a} : {rdy_b, sframe_b}) !== 2'b10) begin
              errors++;
              $display("[TB] FAIL idle_hold dut%0d k=%0d: rdy/sframe=%b, required 10", which, k,
                       (which == 0) ? {rdy_a, sframe_a} : {rdy_b, sframe_b});
            end
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    d_a   = 4'h0;
    d_b   = 4'h0;
    dv_a  = 1'b0;
    dv_b  = 1'b0;
    test_reset();
    test_single_frame();
    test_bit_cycles();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
